// File: rtl/shared_reg_pkg.sv
// Shared types and defaults for the round-robin shared-register arbiter.
// Holds the FSM state encoding and the pointer-width helper.
package shared_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_DEF = 4;
    localparam int W_DEF = 8;

    // A single requester still needs a 1-bit pointer.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PTR_W = ptr_w(N_DEF);

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Rotate-priority picker: first set bit scanning from i_ptr upward, wrapping mod N.
// Purely combinational, zero latency, no flow control.
module rr_pick
    import shared_reg_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int PW = ptr_w(N_DEF)
) (
    input  logic [N-1:0]  i_set,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!o_any && i_set[(int'(i_ptr) + i) % N]) begin
                o_any                              = 1'b1;
                o_onehot[(int'(i_ptr) + i) % N]    = 1'b1;
                o_idx                              = PW'((int'(i_ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one sync-clear register; req -> gnt 1 cycle, gnt -> reg_q 1 cycle.
// Requesters hold req until granted; optional owner lock under SHARED_REG_LOCK_EN.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   op_clr,
    input  logic [N*W-1:0] wdata,
`ifdef SHARED_REG_LOCK_EN
    input  logic [N-1:0]   lock,
`endif
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   reg_q,
    output logic           busy
);

    localparam int PW = ptr_w(N);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  w_gnt_nxt;
    logic [W-1:0]  r_reg;
    logic [W-1:0]  w_reg_nxt;

    logic [N-1:0]  w_set;
    logic [N-1:0]  w_onehot;
    logic [PW-1:0] w_idx;
    logic          w_any;
    logic          w_hold;

    // The current owner is masked so it cannot win two cycles running.
    assign w_set = (r_state == GRANT) ? (req & ~r_gnt) : req;

`ifdef SHARED_REG_LOCK_EN
    assign w_hold = (r_state == GRANT) && (|(lock & req & r_gnt));
`else
    assign w_hold = 1'b0;
`endif

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_rr_pick (
        .i_set    (w_set),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_reg   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_reg   <= w_reg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        if (w_hold || w_any) begin
            w_state_nxt = GRANT;
        end
    end

    always_comb begin
        w_gnt_nxt = '0;
        w_ptr_nxt = r_ptr;
        if (w_hold) begin
            w_gnt_nxt = r_gnt;
        end else if (w_any) begin
            w_gnt_nxt = w_onehot;
            w_ptr_nxt = PW'((int'(w_idx) + 1) % N);
        end
    end

    // op_clr/wdata are taken from the granted requester in the grant cycle itself.
    always_comb begin
        w_reg_nxt = r_reg;
        for (int k = 0; k < N; k++) begin
            if (r_gnt[k]) begin
                w_reg_nxt = op_clr[k] ? '0 : wdata[k*W +: W];
            end
        end
    end

    assign gnt   = r_gnt;
    assign reg_q = r_reg;
    assign busy  = (r_state == GRANT);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           clr_n;
    logic [N-1:0]   req;
    logic [N-1:0]   op_clr;
    logic [N*W-1:0] wdata;
`ifdef SHARED_REG_LOCK_EN
    logic [N-1:0]   lock;
`endif
    logic [N-1:0]   gnt;
    logic [W-1:0]   reg_q;
    logic           busy;

    int n_pass;
    int n_total;

    shared_reg_arbiter #(.N(N), .W(W)) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .req    (req),
        .op_clr (op_clr),
        .wdata  (wdata),
`ifdef SHARED_REG_LOCK_EN
        .lock   (lock),
`endif
        .gnt    (gnt),
        .reg_q  (reg_q),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_n  = 1'b0;
        req    = '0;
        op_clr = '0;
        step();
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        clr_n  = 1'b0;
        req    = 4'b1111;
        op_clr = 4'b0101;
        wdata  = 32'hDEADBEEF;
        step();
        step();
        n_total++;
        if (reg_q !== 8'h00) $display("FAIL reset_reg_q got %h want 00", reg_q); else n_pass++;
        n_total++;
        if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b want 0000", gnt); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        clr_n  = 1'b1;
        req    = 4'b0001;
        op_clr = 4'b0000;
        wdata  = 32'h000000A5;
        step();
        n_total++;
        if (gnt !== 4'b0001) $display("FAIL first_gnt got %b want 0001", gnt); else n_pass++;
        n_total++;
        if (busy !== 1'b1) $display("FAIL first_busy got %b want 1", busy); else n_pass++;
        req = 4'b0000;
        step();
        n_total++;
        if (reg_q !== 8'hA5) $display("FAIL first_write got %h want a5", reg_q); else n_pass++;
        n_total++;
        if (gnt !== 4'b0000 || busy !== 1'b0)
            $display("FAIL first_release gnt %b busy %b want 0000 0", gnt, busy);
        else n_pass++;
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_gnt;
        logic [W-1:0] exp_q;
        do_reset();
        wdata  = 32'h44332211;
        op_clr = 4'b0000;
        req    = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            step();
            exp_gnt = 4'b0001 << (c % 4);
            n_total++;
            if (gnt !== exp_gnt || busy !== 1'b1)
                $display("FAIL fair_gnt_%0d got %b busy %b want %b 1", c, gnt, busy, exp_gnt);
            else n_pass++;
            if (c > 0) begin
                exp_q = 8'(8'h11 * (((c - 1) % 4) + 1));
                n_total++;
                if (reg_q !== exp_q) $display("FAIL fair_reg_%0d got %h want %h", c, reg_q, exp_q);
                else n_pass++;
            end
        end
        req = 4'b0000;
        step();
        n_total++;
        if (gnt !== 4'b0000 || reg_q !== 8'h44)
            $display("FAIL fair_drain gnt %b reg %h want 0000 44", gnt, reg_q);
        else n_pass++;
    endtask

    task automatic test_clear();
        do_reset();
        wdata  = 32'h0077003C;
        op_clr = 4'b0100;
        req    = 4'b0001;
        step();
        req = 4'b0000;
        step();
        n_total++;
        if (reg_q !== 8'h3C) $display("FAIL clear_preload got %h want 3c", reg_q); else n_pass++;
        req = 4'b0100;
        step();
        n_total++;
        if (gnt !== 4'b0100) $display("FAIL clear_gnt got %b want 0100", gnt); else n_pass++;
        req = 4'b0000;
        step();
        n_total++;
        if (reg_q !== 8'h00) $display("FAIL clear_reg got %h want 00", reg_q); else n_pass++;
    endtask

    task automatic test_lone();
        do_reset();
        op_clr = 4'b0000;
        wdata  = 32'h00001100;
        req    = 4'b0010;
        step();
        n_total++;
        if (gnt !== 4'b0010) $display("FAIL lone_g1 got %b want 0010", gnt); else n_pass++;
        wdata[1*W +: W] = 8'h22;
        step();
        n_total++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || reg_q !== 8'h22)
            $display("FAIL lone_gap gnt %b busy %b reg %h want 0000 0 22", gnt, busy, reg_q);
        else n_pass++;
        step();
        n_total++;
        if (gnt !== 4'b0010) $display("FAIL lone_g2 got %b want 0010", gnt); else n_pass++;
        wdata[1*W +: W] = 8'h33;
        step();
        n_total++;
        if (gnt !== 4'b0000 || reg_q !== 8'h33)
            $display("FAIL lone_gap2 gnt %b reg %h want 0000 33", gnt, reg_q);
        else n_pass++;
        req = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        op_clr = 4'b0000;
        wdata  = 32'h00FF005A;
        req    = 4'b0001;
        step();
        req = 4'b0000;
        step();
        n_total++;
        if (reg_q !== 8'h5A) $display("FAIL mid_preload got %h want 5a", reg_q); else n_pass++;
        req = 4'b0100;
        step();
        n_total++;
        if (gnt !== 4'b0100) $display("FAIL mid_gnt got %b want 0100", gnt); else n_pass++;
        clr_n = 1'b0;
        step();
        n_total++;
        if (reg_q !== 8'h00 || gnt !== 4'b0000 || busy !== 1'b0)
            $display("FAIL mid_reset reg %h gnt %b busy %b want 00 0000 0", reg_q, gnt, busy);
        else n_pass++;
        clr_n = 1'b1;
        req   = 4'b1010;
        step();
        n_total++;
        if (gnt !== 4'b0010) $display("FAIL mid_ptr got %b want 0010", gnt); else n_pass++;
        req = 4'b0000;
        step();
    endtask

`ifdef SHARED_REG_LOCK_EN
    task automatic test_lock();
        do_reset();
        lock   = 4'b0001;
        op_clr = 4'b0000;
        wdata  = 32'h00000000;
        req    = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            wdata[0 +: W] = 8'(8'h10 + c);
            step();
            n_total++;
            if (gnt !== 4'b0001) $display("FAIL lock_hold_%0d got %b want 0001", c, gnt); else n_pass++;
        end
        lock = 4'b0000;
        step();
        n_total++;
        if (gnt !== 4'b0010 || reg_q !== 8'h12)
            $display("FAIL lock_release gnt %b reg %h want 0010 12", gnt, reg_q);
        else n_pass++;
        req = 4'b0000;
        step();
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        clr_n   = 1'b0;
        req     = '0;
        op_clr  = '0;
        wdata   = '0;
`ifdef SHARED_REG_LOCK_EN
        lock    = '0;
`endif
        test_reset();
        test_fairness();
        test_clear();
        test_lone();
        test_reset_mid();
`ifdef SHARED_REG_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
